// File: rtl/dp_ram_stream_reader_if.sv
// Bundle between the stream reader, its RAM read port, the job controller and the consumer.
// master: the reader (drives busy/done, RAM address/strobe and the output stream);
// slave: the surroundings (drive start/base/len, RAM data and out_ready).
interface dp_ram_stream_reader_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
);
    logic             start;
    logic [DEPTH-1:0] base;
    logic [DEPTH:0]   len;
    logic             busy;
    logic             done;
    logic [DEPTH-1:0] ram_a;
    logic             ram_rd;
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  start, base, len, ram_q, out_ready,
        output busy, done, ram_a, ram_rd, out_data, out_valid
    );

    modport slave (
        output start, base, len, ram_q, out_ready,
        input  busy, done, ram_a, ram_rd, out_data, out_valid
    );
endinterface

// File: rtl/dp_ram_stream_reader.sv
// Sweeps len words from base over a 1-cycle-latency RAM read port into a valid/ready stream.
// Ports: clk, rst (sync, active-high), bus (dp_ram_stream_reader_if.master).
module dp_ram_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    dp_ram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] base_q, base_d;
    logic [DEPTH:0]   len_q, len_d;
    logic [DEPTH:0]   issued_q, issued_d;
    logic             infl_q;
    logic [WIDTH-1:0] buf_q [2];
    logic             head_q;
    logic [1:0]       occ_q;
    logic             pop;
    logic             room;
    logic             rd;

    assign pop = (occ_q != 2'd0) & bus.out_ready;

    // A read may issue only if its word will still fit when it lands,
    // counting the word already in flight and the one leaving this cycle.
    assign room = (3'(occ_q) + 3'(infl_q)) < (3'd2 + 3'(pop));

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        rd       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d   = bus.base;
                    len_d    = bus.len;
                    issued_d = '0;
                    state_d  = (bus.len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if ((issued_q < len_q) && room) begin
                    rd       = 1'b1;
                    issued_d = issued_q + (DEPTH+1)'(1);
                    if (issued_d == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // all reads issued: the last word leaves when it is alone
                if (pop && (occ_q == 2'd1) && !infl_q) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            infl_q   <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            head_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            infl_q   <= rd;
            // tail slot is head+occ; with a same-cycle pop this is still
            // the slot behind the new head, so ordering is kept
            if (infl_q) buf_q[head_q ^ occ_q[0]] <= bus.ram_q;
            if (pop) head_q <= ~head_q;
            occ_q <= occ_q + 2'(infl_q) - 2'(pop);
        end
    end

    assign bus.ram_rd    = rd;
    assign bus.ram_a     = base_q + issued_q[DEPTH-1:0];
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = buf_q[head_q];
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);
endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// Directed bench for dp_ram_stream_reader (DEPTH=4, RAM[i]=i).
// Monitors sample on negedge; inputs are driven 1 time unit after posedge.
module tb_dp_ram_stream_reader;
    localparam int W = 32;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dp_ram_stream_reader_if #(.WIDTH(W), .DEPTH(D)) bus ();

    dp_ram_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = W'(i);
        bus.ram_q = '0;
    end
    always @(posedge clk) if (bus.ram_rd) bus.ram_q <= mem[bus.ram_a];

    int rmode = 0;
    int rcnt = 0;
    initial bus.out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rmode == 0) begin
            bus.out_ready = 1'b1;
        end else begin
            case (rcnt % 4)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'b0;
                2: bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
            if (rcnt >= 4) bus.out_ready = 1'($urandom_range(0, 1));
            rcnt++;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    int data_q[$];
    int addr_q[$];
    int time_q[$];
    int exp_q[$];
    int done_n = 0;
    int done_t = -1;
    int start_t = -1;
    int first_v = -1;
    int rule_err = 0;
    int stall_err = 0;
    int occ_err = 0;
    int m_occ = 0;
    int m_infl = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [W-1:0] pd = '0;
    logic pbusy = 1'b0;

    always @(negedge clk) begin
        int pop;
        if (rst) begin
            m_occ = 0;
            m_infl = 0;
            pv = 1'b0;
            pbusy = 1'b0;
        end else begin
            pop = int'(bus.out_valid & bus.out_ready);
            if (bus.out_valid != (m_occ != 0)) occ_err++;
            if (bus.ram_rd) begin
                addr_q.push_back(int'(bus.ram_a));
                if (m_occ + m_infl - pop >= 2) rule_err++;
            end
            if (pv && !pr && (!bus.out_valid || bus.out_data != pd)) stall_err++;
            if (pop != 0) begin
                data_q.push_back(int'(bus.out_data));
                time_q.push_back(cyc);
            end
            if (bus.out_valid && first_v < 0) first_v = cyc;
            if (bus.done) begin
                done_n++;
                done_t = cyc;
            end
            if (bus.busy && !pbusy) start_t = cyc;
            m_occ = m_occ + m_infl - pop;
            m_infl = int'(bus.ram_rd);
            pv = bus.out_valid;
            pr = bus.out_ready;
            pd = bus.out_data;
            pbusy = bus.busy;
        end
    end

    task automatic run(input int b, input int l, input int poke);
        int d0;
        data_q.delete();
        addr_q.delete();
        time_q.delete();
        first_v = -1;
        d0 = done_n;
        @(posedge clk);
        #1;
        bus.base = D'(b);
        bus.len = (D+1)'(l);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (poke > 0) begin
            repeat (poke) @(posedge clk);
            #1;
            bus.base = D'(1);
            bus.len = (D+1)'(2);
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        for (int i = 0; i < 300 && done_n == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("done_cnt", done_n - d0, 1);
        @(negedge clk);
        chk("idle", bus.busy, 0);
    endtask

    task automatic cmp(input string tag);
        chk({tag, ".nd"}, data_q.size(), exp_q.size());
        chk({tag, ".na"}, addr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s.a%0d", tag, i),
                i < addr_q.size() ? addr_q[i] : 32'hdead, exp_q[i]);
            chk($sformatf("%s.d%0d", tag, i),
                i < data_q.size() ? data_q[i] : 32'hdead, exp_q[i]);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".done"}, bus.done, 0);
        chk({tag, ".rd"}, bus.ram_rd, 0);
        chk({tag, ".a"}, bus.ram_a, 0);
        chk({tag, ".v"}, bus.out_valid, 0);
        chk({tag, ".q"}, bus.out_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int c0;
        bus.start = 1'b0;
        bus.base = '0;
        bus.len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // streaming, timing of first word and done
        run(4, 6, 0);
        exp_q = {4, 5, 6, 7, 8, 9};
        cmp("t2");
        c0 = start_t;
        chk("t2.first", first_v, c0 + 2);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t2.t%0d", i),
                i < time_q.size() ? time_q[i] : -1, c0 + 2 + i);
        chk("t2.done", done_t, c0 + 8);

        // backpressure
        rcnt = 0;
        rmode = 1;
        run(3, 5, 0);
        rmode = 0;
        exp_q = {3, 4, 5, 6, 7};
        cmp("t3");
        chk("t3.rule", rule_err, 0);
        chk("t3.stall", stall_err, 0);

        // address wrap
        run(14, 4, 0);
        exp_q = {14, 15, 0, 1};
        cmp("t4");

        // empty job
        run(5, 0, 0);
        exp_q.delete();
        cmp("t5z");
        chk("t5z.done", done_t, start_t);

        // full sweep with a start pulsed while busy
        run(7, 16, 5);
        exp_q = {7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 6};
        cmp("t5f");

        // reset mid-job
        data_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        bus.base = D'(2);
        bus.len = (D+1)'(8);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        d0 = done_n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_rst("t1");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        chk("t1.nodone", done_n - d0, 0);
        run(9, 3, 0);
        exp_q = {9, 10, 11};
        cmp("t1");

        chk("occ", occ_err, 0);
        chk("rule", rule_err, 0);
        chk("stall", stall_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
